// File: rtl/loader_pkg.sv
// Shared definitions for the UART program loader: FSM encodings and frame layout constants.
package loader_pkg;

   localparam logic [7:0]  SYNC_DEFAULT  = 8'hA5;
   localparam int unsigned WORD_BYTES    = 4;
   localparam logic [1:0]  LAST_BYTE_IDX = 2'(WORD_BYTES - 1);
   localparam logic [2:0]  RX_LAST_BIT   = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR_H,
      ST_ADDR_L,
      ST_CNT_H,
      ST_CNT_L,
      ST_DATA,
      ST_CSUM
   } ld_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, start-bit glitch rejection.
module uart_rx
   import loader_pkg::*;
#(
   parameter int unsigned DIV = 16
) (
   input  logic       clk_in,
   input  logic       RST,
   input  logic       rxd,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err
);

   localparam int unsigned    CW      = $clog2(DIV);
   localparam logic [CW-1:0]  HALF_M1 = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0]  BIT_M1  = CW'(DIV - 1);

   rx_state_t       r_st, w_st_next;
   logic            r_meta, r_sync, r_prev;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_bit;
   logic [7:0]      r_shift;
   logic            r_bv, r_ferr;
   logic            w_tick;

   always_comb begin
      w_tick    = (r_st == RX_START) ? (r_cnt == HALF_M1) : (r_cnt == BIT_M1);
      w_st_next = r_st;
      case (r_st)
         RX_IDLE:  if (r_prev && !r_sync) w_st_next = RX_START;
         // Line back high at the half-bit check means the edge was a glitch.
         RX_START: if (w_tick) w_st_next = r_sync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (w_tick && (r_bit == RX_LAST_BIT)) w_st_next = RX_STOP;
         RX_STOP:  if (w_tick) w_st_next = RX_IDLE;
         default:  w_st_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (RST) r_st <= RX_IDLE;
      else     r_st <= w_st_next;
   end

   always_ff @(posedge clk_in) begin
      if (RST) begin
         r_meta  <= 1'b1;
         r_sync  <= 1'b1;
         r_prev  <= 1'b1;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_bv    <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_meta <= rxd;
         r_sync <= r_meta;
         r_prev <= r_sync;
         r_cnt  <= ((r_st == RX_IDLE) || w_tick) ? '0 : r_cnt + CW'(1);
         r_bv   <= 1'b0;
         r_ferr <= 1'b0;
         if (w_tick) begin
            case (r_st)
               RX_START: r_bit <= '0;
               RX_DATA: begin
                  r_shift <= {r_sync, r_shift[7:1]};
                  r_bit   <= r_bit + 3'd1;
               end
               RX_STOP: begin
                  r_bv   <= r_sync;
                  r_ferr <= ~r_sync;
               end
               default: ;
            endcase
         end
      end
   end

   assign byte_valid = r_bv;
   assign byte_data  = r_shift;
   assign frame_err  = r_ferr;

endmodule

// File: rtl/uart_mem_loader.sv
// Receives a framed program image over UART and issues word writes, holding the CPU meanwhile.
module uart_mem_loader
   import loader_pkg::*;
#(
   parameter int unsigned CLK_HZ        = 100000000,
   parameter int unsigned BAUD          = 115200,
   parameter int unsigned ADDR_W        = 10,
   parameter logic [7:0]  SYNC          = SYNC_DEFAULT,
   parameter int unsigned TIMEOUT_BYTES = 16
) (
   input  logic              clk_in,
   input  logic              RST,
   input  logic              rxd,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err,
   output logic [15:0]       words_written
);

   localparam int unsigned DIV      = CLK_HZ / BAUD;
   localparam int unsigned TO_LIMIT = TIMEOUT_BYTES * 10 * DIV;
   localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);

   logic              w_bv, w_ferr;
   logic [7:0]        w_byte;
   ld_state_t         r_state, w_state_next;
   logic [7:0]        r_ahi;
   logic [15:0]       r_cnt;
   logic [7:0]        r_csum;
   logic [31:0]       r_word;
   logic [1:0]        r_idx;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_words;
   logic              r_done, r_err;
   logic [TO_W-1:0]   r_to;
   logic              w_set_done, w_set_err, w_timeout;

   uart_rx #(.DIV(DIV)) u_rx (
      .clk_in     (clk_in),
      .RST        (RST),
      .rxd        (rxd),
      .byte_valid (w_bv),
      .byte_data  (w_byte),
      .frame_err  (w_ferr)
   );

   always_comb begin
      w_state_next = r_state;
      w_set_done   = 1'b0;
      w_set_err    = 1'b0;
      w_timeout    = (r_to == TO_W'(TO_LIMIT - 1));
      case (r_state)
         ST_IDLE:   if (w_bv && (w_byte == SYNC)) w_state_next = ST_ADDR_H;
         ST_ADDR_H: if (w_bv) w_state_next = ST_ADDR_L;
         ST_ADDR_L: if (w_bv) w_state_next = ST_CNT_H;
         ST_CNT_H:  if (w_bv) w_state_next = ST_CNT_L;
         ST_CNT_L:  if (w_bv) w_state_next = ({r_cnt[7:0], w_byte} == 16'd0) ? ST_CSUM : ST_DATA;
         ST_DATA:   if (r_we && ((r_words + 16'd1) == r_cnt)) w_state_next = ST_CSUM;
         ST_CSUM: begin
            if (w_bv) begin
               w_state_next = ST_IDLE;
               w_set_done   = (w_byte == r_csum);
               w_set_err    = (w_byte != r_csum);
            end
         end
         default:   w_state_next = ST_IDLE;
      endcase
      if ((r_state != ST_IDLE) && (w_ferr || (w_timeout && !w_bv))) begin
         w_state_next = ST_IDLE;
         w_set_err    = 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (RST) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   always_ff @(posedge clk_in) begin
      if (RST) begin
         r_ahi   <= '0;
         r_cnt   <= '0;
         r_csum  <= '0;
         r_word  <= '0;
         r_idx   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_words <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_to    <= '0;
      end else begin
         // Strobe lands the cycle after the word's 4th byte is assembled.
         r_we <= (r_state == ST_DATA) && w_bv && (r_idx == LAST_BYTE_IDX);
         r_to <= ((r_state == ST_IDLE) || w_bv) ? '0 : r_to + TO_W'(1);
         if (w_bv) begin
            case (r_state)
               ST_IDLE: begin
                  if (w_byte == SYNC) begin
                     r_csum  <= '0;
                     r_done  <= 1'b0;
                     r_err   <= 1'b0;
                     r_words <= '0;
                     r_idx   <= '0;
                  end
               end
               ST_ADDR_H: begin
                  r_ahi  <= w_byte;
                  r_csum <= r_csum ^ w_byte;
               end
               ST_ADDR_L: begin
                  r_addr <= ADDR_W'({r_ahi, w_byte});
                  r_csum <= r_csum ^ w_byte;
               end
               ST_CNT_H, ST_CNT_L: begin
                  r_cnt  <= {r_cnt[7:0], w_byte};
                  r_csum <= r_csum ^ w_byte;
               end
               ST_DATA: begin
                  r_word <= {r_word[23:0], w_byte};
                  r_idx  <= r_idx + 2'd1;
                  r_csum <= r_csum ^ w_byte;
               end
               default: ;
            endcase
         end
         if (r_we) begin
            r_addr  <= r_addr + ADDR_W'(1);
            r_words <= r_words + 16'd1;
         end
         if (w_set_done) r_done <= 1'b1;
         if (w_set_err)  r_err  <= 1'b1;
      end
   end

   assign mem_we        = r_we;
   assign mem_addr      = r_addr;
   assign mem_wdata     = r_word;
   assign cpu_hold      = (r_state != ST_IDLE);
   assign load_done     = r_done;
   assign load_err      = r_err;
   assign words_written = r_words;

endmodule
